// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: round-robin owner of a 2:1 mux select; define ARB_BURST_LIMIT_EN to cap bursts at MAX_HOLD words
module mux2_rr_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             dout_sel
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t state, next;
  logic last, xfer, at_limit;
  assign gnt0 = state == OWN0;
  assign gnt1 = state == OWN1;
  assign xfer = (gnt0 & req0) | (gnt1 & req1);
`ifdef ARB_BURST_LIMIT_EN
  localparam logic [7:0] HOLD_TOP = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt;
  assign at_limit = xfer && hold_cnt == HOLD_TOP;
  // count words in the current grant, restarting whenever the owner changes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) hold_cnt <= '0;
    else if (next != state) hold_cnt <= '0;
    else if (xfer && hold_cnt != HOLD_TOP) hold_cnt <= hold_cnt + 8'd1;
`else
  assign at_limit = 1'b0;
`endif
  // next owner: released or exhausted grants hand straight to a waiting peer
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = (req0 && (!req1 || last)) ? OWN0 : req1 ? OWN1 : IDLE;
      OWN0:    next = (req1 && (!req0 || at_limit)) ? OWN1 : req0 ? OWN0 : IDLE;
      OWN1:    next = (req0 && (!req1 || at_limit)) ? OWN0 : req1 ? OWN1 : IDLE;
      default: next = IDLE;
    endcase
  end
  // state register and last-served source
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= next;
      if (next != IDLE) last <= next == OWN1;
    end
  // registered mux output; the word only changes on a transfer
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_sel   <= 1'b0;
    end else begin
      if (xfer) dout <= gnt0 ? din0 : din1;
      dout_valid <= xfer;
      dout_sel   <= gnt1;
    end
endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb_mux2_rr_arbiter: directed checks of grant, handoff, round-robin, reset and burst behaviour
module tb_mux2_rr_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] din0 = '0, din1 = '0;
  logic       gnt0, gnt1, dout_valid, dout_sel;
  logic [7:0] dout;
  int         errs = 0, checks = 0;

  mux2_rr_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .din0(din0), .din1(din1),
    .gnt0(gnt0), .gnt1(gnt1), .dout(dout), .dout_valid(dout_valid), .dout_sel(dout_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".gnt0"}, gnt0, 0);
    check({tag, ".gnt1"}, gnt1, 0);
    check({tag, ".dout"}, dout, 0);
    check({tag, ".valid"}, dout_valid, 0);
    check({tag, ".sel"}, dout_sel, 0);
  endtask

  initial begin
    logic [7:0] words [3];
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    // power-on reset
    tick;
    check_zero("por");
    @(negedge clk) rst_n = 1'b1;
    // single source
    req0 = 1'b1; din0 = words[0];
    tick;
    check("single.gnt0", gnt0, 1);
    check("single.gnt1", gnt1, 0);
    check("single.novalid", dout_valid, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      check("single.dout", dout, words[i]);
      check("single.valid", dout_valid, 1);
      check("single.sel", dout_sel, 0);
      if (i < 2) din0 = words[i+1];
    end
    req0 = 1'b0;
    tick;
    check("release.gnt0", gnt0, 0);
    check("release.valid", dout_valid, 0);
    check("release.hold", dout, 8'h33);
    // round-robin: source 0 was last, so source 1 wins the tie
    req0 = 1'b1; req1 = 1'b1; din0 = 8'hD0; din1 = 8'hC1;
    tick;
    check("rr.gnt1", gnt1, 1);
    check("rr.gnt0", gnt0, 0);
    tick;
    check("rr.dout", dout, 8'hC1);
    check("rr.sel", dout_sel, 1);
    req0 = 1'b0; req1 = 1'b0;
    tick;
    check("rr.idle", gnt0 | gnt1, 0);
    // handoff: source 1 now last, tie goes to source 0, then 0 releases
    req0 = 1'b1; req1 = 1'b1; din0 = 8'hA0; din1 = 8'h5B;
    tick;
    check("ho.gnt0", gnt0, 1);
    tick;
    check("ho.w0", dout, 8'hA0);
    din0 = 8'hA1;
    tick;
    check("ho.w1", dout, 8'hA1);
    check("ho.w1sel", dout_sel, 0);
    req0 = 1'b0;
    tick;
    check("ho.gnt0off", gnt0, 0);
    check("ho.gnt1on", gnt1, 1);
    tick;
    check("ho.dout", dout, 8'h5B);
    check("ho.sel", dout_sel, 1);
    check("ho.valid", dout_valid, 1);
    req1 = 1'b0;
    tick;
    // mid-burst reset: source 1 was last, so source 0 owns
    req0 = 1'b1; req1 = 1'b1; din0 = 8'h0F; din1 = 8'hF0;
    tick;
    check("mid.gnt0", gnt0, 1);
    tick;
    check("mid.valid", dout_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check_zero("async");
    @(negedge clk) rst_n = 1'b1;
    tick;
    check("post.gnt0", gnt0, 1);
    check("post.gnt1", gnt1, 0);
    // sustained contention
    for (int i = 0; i < 10; i++) begin
      logic exp_sel;
      tick;
`ifdef ARB_BURST_LIMIT_EN
      exp_sel = 1'((i / 4) % 2);
`else
      exp_sel = 1'b0;
      check("burst.gnt1", gnt1, 0);
`endif
      check("burst.valid", dout_valid, 1);
      check("burst.sel", dout_sel, exp_sel);
      check("burst.dout", dout, exp_sel ? 8'hF0 : 8'h0F);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
